// File: rtl/vga_rect_plotter_pkg.sv
// Shared definitions for the rectangle plotter: FSM encoding and default screen geometry.
package vga_rect_plotter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDraw = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DefaultScreenW = 160;
   localparam int unsigned DefaultScreenH = 120;

endpackage

// File: rtl/vga_rect_counter.sv
// Row-major 2-D pixel counter: cx runs 0..w-1, then wraps while cy steps 0..h-1.
module vga_rect_counter #(
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          advance_i,
   input  logic [DW-1:0] w_i,
   input  logic [DW-1:0] h_i,
   output logic [DW-1:0] cx_o,
   output logic [DW-1:0] cy_o,
   output logic          last_x_o,
   output logic          last_o
);

   logic [DW-1:0] cx_q, cx_d, cy_q, cy_d;
   logic          last_x, last_y;

   assign last_x = (cx_q == w_i - DW'(1));
   assign last_y = (cy_q == h_i - DW'(1));

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clear_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (advance_i) begin
         if (last_x) begin
            cx_d = '0;
            // Wrap cy on the final pixel so it never exceeds h-1.
            cy_d = last_y ? '0 : cy_q + DW'(1);
         end else begin
            cx_d = cx_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign cx_o     = cx_q;
   assign cy_o     = cy_q;
   assign last_x_o = last_x;
   assign last_o   = last_x & last_y;

endmodule

// File: rtl/vga_rect_plotter.sv
// Fills a rectangle one pixel per accepted plot, clipping off-screen pixels without stalling.
module vga_rect_plotter
   import vga_rect_plotter_pkg::*;
#(
   parameter int unsigned     CW           = 9,
   parameter int unsigned     DW           = 8,
   parameter int unsigned     COLW         = 6,
   parameter int unsigned     SCREEN_W     = DefaultScreenW,
   parameter int unsigned     SCREEN_H     = DefaultScreenH,
   parameter logic [COLW-1:0] CLEAR_COLOUR = '0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            clear,
   input  logic [CW-1:0]   x_in,
   input  logic [CW-1:0]   y_in,
   input  logic [DW-1:0]   w_in,
   input  logic [DW-1:0]   h_in,
   input  logic [COLW-1:0] colour_in,
   input  logic            plot_ack,
   output logic [CW-1:0]   x,
   output logic [CW-1:0]   y,
   output logic [COLW-1:0] colour,
   output logic            plot,
   output logic            ready,
   output logic            done
);

   state_e          state_q, state_d;
   logic [CW-1:0]   x0_q, y0_q, x_hold_q, y_hold_q;
   logic [DW-1:0]   w_q, h_q, cx, cy;
   logic [COLW-1:0] col_q, col_hold_q;
   logic [CW:0]     sum_x, sum_y;
   logic            accept, cnt_clear, advance, last, last_x, onscreen;

   vga_rect_counter #(
      .DW (DW)
   ) u_counter (
      .clk_i     (clk),
      .rst_ni    (resetn),
      .clear_i   (cnt_clear),
      .advance_i (advance),
      .w_i       (w_q),
      .h_i       (h_q),
      .cx_o      (cx),
      .cy_o      (cy),
      .last_x_o  (last_x),
      .last_o    (last)
   );

   // Extra MSB catches coordinate overflow past 2^CW.
   assign sum_x    = {1'b0, x0_q} + (CW+1)'(cx);
   assign sum_y    = {1'b0, y0_q} + (CW+1)'(cy);
   assign onscreen = !sum_x[CW] && !sum_y[CW] &&
                     (sum_x < (CW+1)'(SCREEN_W)) && (sum_y < (CW+1)'(SCREEN_H));

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      cnt_clear = 1'b0;
      advance   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept    = 1'b1;
               cnt_clear = 1'b1;
               state_d   = (w_in == '0 || h_in == '0) ? StDone : StDraw;
            end
         end
         StDraw: begin
            // Off-screen pixels are skipped at one per cycle; on-screen ones wait for ack.
            advance = !onscreen || plot_ack;
            if (advance && last) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         x_hold_q   <= '0;
         y_hold_q   <= '0;
         col_hold_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            x0_q  <= x_in;
            y0_q  <= y_in;
            w_q   <= w_in;
            h_q   <= h_in;
            col_q <= clear ? CLEAR_COLOUR : colour_in;
         end
         if (state_q == StDraw) begin
            x_hold_q   <= sum_x[CW-1:0];
            y_hold_q   <= sum_y[CW-1:0];
            col_hold_q <= col_q;
         end
      end
   end

   assign x      = (state_q == StDraw) ? sum_x[CW-1:0] : x_hold_q;
   assign y      = (state_q == StDraw) ? sum_y[CW-1:0] : y_hold_q;
   assign colour = (state_q == StDraw) ? col_q : col_hold_q;
   assign plot   = (state_q == StDraw) && onscreen;
   assign ready  = (state_q == StIdle);
   assign done   = (state_q == StDone);

   logic unused_last_x;
   assign unused_last_x = last_x;

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Directed self-checking bench for vga_rect_plotter.
module tb_vga_rect_plotter;

   localparam int CW   = 9;
   localparam int DW   = 8;
   localparam int COLW = 6;

   logic            clk, resetn, start, clear, plot_ack;
   logic [CW-1:0]   x_in, y_in, x, y;
   logic [DW-1:0]   w_in, h_in;
   logic [COLW-1:0] colour_in, colour;
   logic            plot, ready, done;

   int checks   = 0;
   int failures = 0;

   vga_rect_plotter dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .clear     (clear),
      .x_in      (x_in),
      .y_in      (y_in),
      .w_in      (w_in),
      .h_in      (h_in),
      .colour_in (colour_in),
      .plot_ack  (plot_ack),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .ready     (ready),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic scramble();
      logic [31:0] r;
      r = $urandom;
      x_in      = r[8:0];
      y_in      = r[17:9];
      w_in      = r[25:18];
      colour_in = r[31:26];
      r = $urandom;
      h_in      = r[7:0];
      clear     = r[8];
   endtask

   // Drives start for one edge; returns #1 after that edge with inputs scrambled.
   task automatic issue(input int xi, input int yi, input int wi, input int hi,
                        input int ci, input bit clr);
      logic [31:0] vx, vy, vw, vh, vc;
      vx = xi; vy = yi; vw = wi; vh = hi; vc = ci;
      x_in = vx[8:0]; y_in = vy[8:0]; w_in = vw[7:0]; h_in = vh[7:0];
      colour_in = vc[5:0]; clear = clr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
   endtask

   // Walks the rectangle in row-major order, checking each DRAW cycle.
   task automatic run_rect(input string tag, input int x0, input int y0, input int w,
                           input int h, input int col, input int stall, input bit poke,
                           input int exp_cycles, input int exp_pix);
      int  cyc, npix, k, ex, ey;
      bit  seen_done, on;
      cyc = 1; npix = 0; k = 0; seen_done = 0;
      while (!seen_done && cyc < 2000) begin
         plot_ack = (cyc > stall);
         start    = poke && (cyc == 2);
         @(negedge clk);
         if (done) begin
            seen_done = 1;
            check_eq({tag, ".done_plot"}, 32'(plot), 0);
         end else begin
            ex = x0 + (w > 0 ? k % w : 0);
            ey = y0 + (w > 0 ? k / w : 0);
            on = (ex < 160) && (ey < 120);
            check_eq({tag, ".plot"}, 32'(plot), 32'(on));
            if (on) begin
               check_eq({tag, ".x"}, 32'(x), ex);
               check_eq({tag, ".y"}, 32'(y), ey);
               check_eq({tag, ".colour"}, 32'(colour), col);
            end
            if (plot && plot_ack) npix++;
            if (!on || plot_ack) k++;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (!seen_done) cyc++;
      end
      check_eq({tag, ".done_cycle"}, cyc, exp_cycles);
      check_eq({tag, ".pixels"}, npix, exp_pix);
      @(negedge clk);
      check_eq({tag, ".ready_after"}, 32'(ready), 1);
      check_eq({tag, ".done_once"}, 32'(done), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int dones;
      start = 0; clear = 0; plot_ack = 1; resetn = 0;
      x_in = '0; y_in = '0; w_in = '0; h_in = '0; colour_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst.ready", 32'(ready), 1);
      check_eq("rst.plot", 32'(plot), 0);
      check_eq("rst.done", 32'(done), 0);
      check_eq("rst.x", 32'(x), 0);
      check_eq("rst.y", 32'(y), 0);
      check_eq("rst.colour", 32'(colour), 0);
      resetn = 1;
      @(posedge clk); #1;

      issue(10, 44, 4, 4, 6'b001001, 0);
      run_rect("basic", 10, 44, 4, 4, 9, 0, 0, 17, 16);
      @(negedge clk);
      check_eq("basic.hold_x", 32'(x), 13);
      check_eq("basic.hold_y", 32'(y), 47);
      @(posedge clk); #1;

      issue(20, 30, 2, 1, 6'h15, 0);
      run_rect("bp", 20, 30, 2, 1, 6'h15, 3, 0, 6, 2);

      issue(158, 0, 4, 1, 6'h2A, 0);
      run_rect("clip", 158, 0, 4, 1, 6'h2A, 0, 0, 5, 2);

      issue(0, 118, 1, 4, 6'h07, 0);
      run_rect("clipy", 0, 118, 1, 4, 6'h07, 0, 0, 5, 2);

      issue(3, 4, 2, 2, 6'h3F, 1);
      run_rect("clear", 3, 4, 2, 2, 0, 0, 0, 5, 4);

      issue(3, 4, 0, 5, 6'h3F, 1);
      run_rect("w0", 3, 4, 0, 5, 0, 0, 0, 1, 0);

      issue(50, 60, 3, 2, 6'h05, 0);
      run_rect("poke", 50, 60, 3, 2, 6'h05, 0, 1, 7, 6);

      issue(10, 10, 4, 4, 6'h11, 0);
      repeat (3) @(posedge clk);
      #1 resetn = 0;
      #1;
      check_eq("midrst.plot", 32'(plot), 0);
      check_eq("midrst.done", 32'(done), 0);
      check_eq("midrst.x", 32'(x), 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check_eq("midrst.no_done", dones, 0);
      check_eq("midrst.ready", 32'(ready), 1);
      @(posedge clk); #1;

      issue(5, 5, 1, 1, 6'h22, 0);
      run_rect("after_rst", 5, 5, 1, 1, 6'h22, 0, 0, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_rect_plotter.md
VGA_RECT_PLOTTER -- requirements
Module: vga_rect_plotter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CW, 9, coordinate width; DW, 8, rectangle dimension width; COLW, 6, colour width; SCREEN_W, 160, visible columns; SCREEN_H, 120, visible rows; CLEAR_COLOUR, 6'b000000, fill colour for clear mode.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, request a rectangle fill.
- clear, in, 1, sampled with start; 1 selects CLEAR_COLOUR instead of colour_in.
- x_in / y_in, in, CW, top-left corner.
- w_in / h_in, in, DW, width and height in pixels.
- colour_in, in, COLW, fill colour.
- plot_ack, in, 1, downstream VGA adapter accepted the current pixel.
- x / y, out, CW, pixel coordinate.
- colour, out, COLW, pixel colour.
- plot, out, 1, pixel valid (write enable).
- ready, out, 1, idle and able to accept start.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, DRAW and DONE.
REQ-004 In IDLE, ready SHALL be 1; start=1 SHALL latch x_in, y_in, w_in, h_in and the resolved colour, clear both counters (cx, cy) to 0, and move to DRAW on the next edge.
REQ-005 If start is accepted with w_in=0 or h_in=0, the FSM SHALL go IDLE->DONE and emit no pixel.
REQ-006 In DRAW, the outputs SHALL be x = x0+cx and y = y0+cy, computed at CW+1 bits to detect overflow; colour SHALL be the latched colour.
REQ-007 Pixel order SHALL be row-major: cx increments to w-1, then wraps to 0 while cy increments.
REQ-008 plot SHALL be 1 in DRAW only when the pixel is on-screen (x<SCREEN_W, y<SCREEN_H, no overflow).
REQ-009 On-screen pixel (plot=1): the pixel SHALL be held stable while plot_ack=0, and the counters SHALL advance on the edge where plot_ack=1.
REQ-010 Off-screen pixel: plot SHALL be 0, and the counters SHALL advance unconditionally one per cycle (clipping, no stall).
REQ-011 Advancing from the pixel at cx=w-1, cy=h-1 SHALL move the FSM to DONE; done=1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-012 start while not in IDLE SHALL be ignored; the latched parameters SHALL be unaffected.
REQ-013 Input changes after acceptance SHALL NOT affect the rectangle in progress.
REQ-014 Maximum area SHALL be (2^DW-1)^2 pixels; the counters SHALL be DW bits each and SHALL never exceed w-1 / h-1.
REQ-015 Outside DRAW, plot SHALL be 0 and x, y, colour SHALL hold their last values.
REQ-016 All outputs SHALL be registered or decoded from state/registers only; there SHALL be no combinational path from start to plot.

Reset
REQ-017 resetn=0 SHALL force, asynchronously: state=IDLE, cx=cy=0, x=y=0, colour=0, plot=0, done=0, ready=1 (once the reset is released).
REQ-018 Reset mid-DRAW SHALL abandon the rectangle; no done pulse SHALL follow.
REQ-019 The first start after reset release SHALL be accepted normally.

Structure
REQ-020 A shared package SHALL hold the state encoding (IDLE, DRAW, DONE) and the default screen constants SCREEN_W and SCREEN_H.
REQ-021 The design SHALL be one module with a split control FSM and datapath; sub-module vga_rect_counter (a 2-D cx/cy counter with advance, wrap and last flags) is natural and allowed.

Verification
REQ-022 Basic fill: x=10, y=44, w=4, h=4, colour 6'b001001, plot_ack held 1 -> 16 pixels (10..13, 44..47) in row-major order; done 17 cycles after start; then ready=1.
REQ-023 Backpressure: w=2, h=1, plot_ack low for 3 cycles on the first pixel -> (x0, y0) held 4 cycles; exactly 2 pixels emitted; no duplicates.
REQ-024 Clipping: x=158, y=0, w=4, h=1 -> plot=1 for x=158 and 159 only; done still occurs after 4 DRAW cycles.
REQ-025 Clear mode: clear=1, colour_in=6'h3F -> every pixel has colour=CLEAR_COLOUR; w=0 -> done one cycle after start with no plot.
REQ-026 Reset mid-operation and ignored start: pulse start during DRAW -> the rectangle is unchanged; assert resetn=0 mid-DRAW -> plot=0 immediately, no done, ready=1 after release.
